// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if
// Instruction-memory bus between the fetch stage and the instruction memory.
//   imem_addr  : word address presented by the fetch stage (always 4-aligned)
//   imem_rdata : instruction word, combinational read of imem_addr
// Modports:
//   master : the fetch stage (drives the address, receives the word)
//   slave  : the instruction memory (receives the address, returns the word)
// ----------------------------------------------------------------------------
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage plus IF/ID pipeline register of the 32-bit pipelined
// RISC core. Holds the program counter, presents it on the instruction-memory
// bus and latches the returned word into IF/ID. A taken branch or a jump
// redirects the PC and replaces IF/ID with a bubble; a load-use stall freezes
// both the PC and IF/ID.
//
// Ports:
//   clk           : clock, all state changes on the rising edge
//   res           : synchronous active-high reset
//   stall         : hold PC and IF/ID (hazard unit)
//   branch_taken  : resolved taken branch from a later stage (highest priority)
//   branch_target : branch destination, bits [1:0] discarded
//   jump          : jump decoded in ID
//   jump_target   : jump destination, bits [1:0] discarded
//   imem          : instruction-memory bus (master side)
//   pc            : current fetch PC
//   ifid_instr    : registered instruction word
//   ifid_pc4      : registered PC+4 belonging to ifid_instr
//   ifid_valid    : 1 = real instruction, 0 = bubble
//   opcode        : ifid_instr[31:26], straight to the decode control unit
//
// Parameters:
//   RESET_PC  : PC loaded on reset
//   NOP_INSTR : bubble word written into IF/ID on reset and on flush
// ----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              res,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  if_stage_if.master        imem,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc4,
  output logic              ifid_valid,
  output logic [5:0]        opcode
);

  // Per-cycle action. This is not a held state: every cycle picks one action
  // purely from the current inputs, in priority order.
  typedef enum logic [2:0] {
    ACT_RESET  = 3'd0,
    ACT_BRANCH = 3'd1,
    ACT_JUMP   = 3'd2,
    ACT_STALL  = 3'd3,
    ACT_FETCH  = 3'd4
  } act_t;

  // Clears the two byte-offset bits of a redirect target. Masking (rather than
  // slicing) keeps every input bit used.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  act_t        act_s;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] pc4_r;
  logic        valid_r;

  logic [31:0] pc_plus4_s;
  logic [31:0] pc_nxt_s;
  logic [31:0] instr_nxt_s;
  logic [31:0] pc4_nxt_s;
  logic        valid_nxt_s;

  // Modulo-2^32 increment; FFFF_FFFC wraps to 0 and the same sum feeds IF/ID.
  assign pc_plus4_s = pc_r + 32'd4;

  // Action select: res > branch_taken > jump > stall > sequential fetch.
  // The branch comes from an older instruction than the jump in ID, so it
  // wins; a jump ignores stall because the jump itself has left IF/ID.
  always_comb begin
    act_s = ACT_FETCH;
    if (res) begin
      act_s = ACT_RESET;
    end else if (branch_taken) begin
      act_s = ACT_BRANCH;
    end else if (jump) begin
      act_s = ACT_JUMP;
    end else if (stall) begin
      act_s = ACT_STALL;
    end else begin
      act_s = ACT_FETCH;
    end
  end

  // Next values of PC and IF/ID for the selected action.
  always_comb begin
    pc_nxt_s    = pc_r;
    instr_nxt_s = instr_r;
    pc4_nxt_s   = pc4_r;
    valid_nxt_s = valid_r;
    case (act_s)
      ACT_RESET: begin
        pc_nxt_s    = RESET_PC;
        instr_nxt_s = NOP_INSTR;
        pc4_nxt_s   = 32'h0000_0000;
        valid_nxt_s = 1'b0;
      end
      ACT_BRANCH: begin
        pc_nxt_s    = align_word(branch_target);
        instr_nxt_s = NOP_INSTR;
        pc4_nxt_s   = 32'h0000_0000;
        valid_nxt_s = 1'b0;
      end
      ACT_JUMP: begin
        pc_nxt_s    = align_word(jump_target);
        instr_nxt_s = NOP_INSTR;
        pc4_nxt_s   = 32'h0000_0000;
        valid_nxt_s = 1'b0;
      end
      ACT_STALL: begin
        pc_nxt_s    = pc_r;
        instr_nxt_s = instr_r;
        pc4_nxt_s   = pc4_r;
        valid_nxt_s = valid_r;
      end
      ACT_FETCH: begin
        pc_nxt_s    = pc_plus4_s;
        instr_nxt_s = imem.imem_rdata;
        pc4_nxt_s   = pc_plus4_s;
        valid_nxt_s = 1'b1;
      end
      default: begin
        // Unreachable encodings fall back to a flush so the pipe never sees
        // a stale word marked valid.
        pc_nxt_s    = RESET_PC;
        instr_nxt_s = NOP_INSTR;
        pc4_nxt_s   = 32'h0000_0000;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // PC and IF/ID registers; reset is folded into the action select above.
  always_ff @(posedge clk) begin
    pc_r    <= pc_nxt_s;
    instr_r <= instr_nxt_s;
    pc4_r   <= pc4_nxt_s;
    valid_r <= valid_nxt_s;
  end

  assign pc             = pc_r;
  assign imem.imem_addr = pc_r;
  assign ifid_instr     = instr_r;
  assign ifid_pc4       = pc4_r;
  assign ifid_valid     = valid_r;
  assign opcode         = instr_r[31:26];

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. A behavioural model of the fetch stage runs
// alongside the DUT and a compare process checks every cycle; hand-computed
// literals at key points pin the model. A second instance with
// RESET_PC = FFFF_FFFC checks PC wrap-around.
// ----------------------------------------------------------------------------
module tb_if_stage;

  logic        clk = 1'b0;
  logic        res, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, ifid_instr, ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  opcode;
  logic [31:0] pc2, ifid_instr2, ifid_pc42;
  logic        ifid_valid2;
  logic [5:0]  opcode2;

  int vectors = 0;
  int miscompares = 0;

  if_stage_if bus ();
  if_stage_if bus2 ();

  // Instruction memory contents: three program words, everything else a
  // recognisable address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0004: return 32'h3822_000E;
      32'h0000_0008: return 32'h0022_1820;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign bus.imem_rdata  = mem_word(bus.imem_addr);
  assign bus2.imem_rdata = mem_word(bus2.imem_addr);

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .res(res), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem(bus.master),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .opcode(opcode)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .res(res), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem(bus2.master),
    .pc(pc2), .ifid_instr(ifid_instr2), .ifid_pc4(ifid_pc42),
    .ifid_valid(ifid_valid2), .opcode(opcode2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the fetch stage as an architectural description.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic        m_known = 1'b0;

  always @(posedge clk) begin
    if (res) begin
      m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
      m_known <= 1'b1;
    end else if (branch_taken || jump) begin
      m_pc    <= (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
      m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
    end else if (!stall) begin
      m_instr <= mem_word(m_pc);
      m_pc4   <= m_pc + 32'd4;
      m_pc    <= m_pc + 32'd4;
      m_valid <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc4", ifid_pc4, m_pc4);
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      chk("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
  endtask

  initial begin
    res = 1'b1;
    idle();
    step(); step();
    // reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc4", ifid_pc4, 32'h0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_wrap_pc", pc2, 32'hFFFF_FFFC);

    res = 1'b0;
    step();
    chk("f0_pc", pc, 32'h4);
    chk("f0_instr", ifid_instr, 32'h2001_0005);
    chk("f0_pc4", ifid_pc4, 32'h4);
    chk("f0_valid", {31'd0, ifid_valid}, 32'd1);
    chk("f0_opcode", {26'd0, opcode}, {26'd0, 6'b001000});
    chk("wrap_pc", pc2, 32'h0);
    chk("wrap_pc4", ifid_pc42, 32'h0);
    chk("wrap_instr", ifid_instr2, 32'hA5A5_FFFC);
    step();
    chk("f1_pc", pc, 32'h8);
    chk("f1_instr", ifid_instr, 32'h3822_000E);
    chk("f1_opcode", {26'd0, opcode}, {26'd0, 6'b001110});

    // two-cycle stall
    stall = 1'b1;
    step();
    chk("st1_pc", pc, 32'h8);
    chk("st1_instr", ifid_instr, 32'h3822_000E);
    step();
    chk("st2_pc", pc, 32'h8);
    chk("st2_instr", ifid_instr, 32'h3822_000E);
    stall = 1'b0;
    step();
    chk("rel_instr", ifid_instr, 32'h0022_1820);
    chk("rel_pc4", ifid_pc4, 32'hC);
    chk("rel_pc", pc, 32'hC);
    chk("rel_opcode", {26'd0, opcode}, 32'd0);
    step();
    chk("seq_instr", ifid_instr, 32'h5A5A_000C);

    // branch beats jump and stall
    branch_taken = 1'b1; branch_target = 32'h40;
    jump = 1'b1; jump_target = 32'h80; stall = 1'b1;
    step();
    chk("br_pc", pc, 32'h40);
    chk("br_instr", ifid_instr, 32'h0);
    chk("br_valid", {31'd0, ifid_valid}, 32'd0);
    idle();
    step();
    chk("br_tgt_instr", ifid_instr, 32'h5A5A_0040);
    chk("br_tgt_valid", {31'd0, ifid_valid}, 32'd1);
    chk("br_tgt_pc4", ifid_pc4, 32'h44);

    // unaligned jump overriding a stall
    jump = 1'b1; jump_target = 32'h103; stall = 1'b1;
    step();
    chk("jmp_pc", pc, 32'h100);
    chk("jmp_valid", {31'd0, ifid_valid}, 32'd0);
    idle();
    step();
    chk("jmp_tgt_instr", ifid_instr, 32'h5A5A_0100);
    chk("jmp_tgt_pc4", ifid_pc4, 32'h104);

    // back-to-back redirects: the second wins
    jump = 1'b1; jump_target = 32'h200;
    step();
    chk("b2b1_valid", {31'd0, ifid_valid}, 32'd0);
    idle();
    branch_taken = 1'b1; branch_target = 32'h302;
    step();
    chk("b2b2_pc", pc, 32'h300);
    chk("b2b2_valid", {31'd0, ifid_valid}, 32'd0);
    idle();
    step();
    chk("b2b_instr", ifid_instr, 32'h5A5A_0300);

    // reset during a jump at pc = 0x24
    jump = 1'b1; jump_target = 32'h24;
    step();
    chk("pre_rst_pc", pc, 32'h24);
    jump_target = 32'h80; stall = 1'b1; branch_taken = 1'b1;
    branch_target = 32'h60; res = 1'b1;
    step();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("mid_rst_instr", ifid_instr, 32'h0);
    res = 1'b0;
    idle();
    step();
    chk("post_rst_instr", ifid_instr, 32'h2001_0005);
    chk("post_rst_pc", pc, 32'h4);

    // a few more cycles mixing single stalls and plain fetches
    for (int i = 0; i < 8; i++) begin
      stall = (i % 3 == 1);
      step();
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
